// File: rtl/inst_fetcher.sv
// Instruction fetch front end: fetch PC, direct-mapped one-word-per-line I-cache,
// single-entry output slot toward the decoder, and ROB-driven redirect.
module inst_fetcher #(
  parameter int          ICACHE_ENTRIES = 64,
  parameter logic [31:0] RESET_PC       = 32'h00000000,
  parameter logic [31:0] EMPTY_PC       = 32'hFFFFFFFF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_station_idle,
  output logic [31:0] inst_to_dec,
  output logic [31:0] pc_to_dec,
  output logic        if_ls_to_dec,
  output logic        mem_fetch_req,
  output logic [31:0] mem_fetch_addr,
  input  logic        mem_fetch_done,
  input  logic [31:0] mem_fetch_inst,
  input  logic        rob_jump_flag,
  input  logic [31:0] rob_jump_pc
);
  localparam int INDEX_BITS = $clog2(ICACHE_ENTRIES);
  localparam int TAG_BITS   = 32 - INDEX_BITS - 2;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic        discard, discard_nx;
  logic [31:0] inst_nx, slot_pc_nx, addr_nx;
  logic        ls_nx, req_nx, fill_en;

  logic [ICACHE_ENTRIES-1:0] line_valid;
  logic [TAG_BITS-1:0]       line_tag  [ICACHE_ENTRIES];
  logic [31:0]               line_data [ICACHE_ENTRIES];

  logic [INDEX_BITS-1:0] pc_index, fill_index;
  logic [TAG_BITS-1:0]   pc_tag, fill_tag;
  logic                  hit, slot_valid, slot_free;

  function automatic logic is_load_store(input logic [31:0] inst);
    return (inst[6:0] == 7'b0000011) || (inst[6:0] == 7'b0100011);
  endfunction

  assign pc_index   = pc[INDEX_BITS+1:2];
  assign pc_tag     = pc[31:INDEX_BITS+2];
  assign fill_index = mem_fetch_addr[INDEX_BITS+1:2];
  assign fill_tag   = mem_fetch_addr[31:INDEX_BITS+2];
  assign hit        = line_valid[pc_index] && (line_tag[pc_index] == pc_tag);
  assign slot_valid = (pc_to_dec != EMPTY_PC);
  assign slot_free  = !slot_valid || if_station_idle;

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    discard_nx = discard;
    inst_nx    = inst_to_dec;
    slot_pc_nx = pc_to_dec;
    ls_nx      = if_ls_to_dec;
    req_nx     = mem_fetch_req;
    addr_nx    = mem_fetch_addr;
    fill_en    = 1'b0;

    if (slot_valid && if_station_idle) begin
      slot_pc_nx = EMPTY_PC;
      ls_nx      = 1'b0;
    end

    if (rob_jump_flag) begin
      // Redirect wins; an in-flight fetch still completes into the cache but is never presented.
      slot_pc_nx = EMPTY_PC;
      ls_nx      = 1'b0;
      pc_nx      = rob_jump_pc;
      if (state == WAIT_MEM) begin
        if (mem_fetch_done) begin
          fill_en    = 1'b1;
          req_nx     = 1'b0;
          state_nx   = IDLE;
          discard_nx = 1'b0;
        end else begin
          discard_nx = 1'b1;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (slot_free) begin
            if (hit) begin
              inst_nx    = line_data[pc_index];
              slot_pc_nx = pc;
              ls_nx      = is_load_store(line_data[pc_index]);
              pc_nx      = pc + 32'd4;
            end else begin
              req_nx   = 1'b1;
              addr_nx  = pc;
              state_nx = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_fetch_done) begin
            fill_en  = 1'b1;
            req_nx   = 1'b0;
            state_nx = IDLE;
            if (discard) begin
              discard_nx = 1'b0;
            end else begin
              inst_nx    = mem_fetch_inst;
              slot_pc_nx = mem_fetch_addr;
              ls_nx      = is_load_store(mem_fetch_inst);
              pc_nx      = pc + 32'd4;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      discard        <= 1'b0;
      inst_to_dec    <= 32'd0;
      pc_to_dec      <= EMPTY_PC;
      if_ls_to_dec   <= 1'b0;
      mem_fetch_req  <= 1'b0;
      mem_fetch_addr <= 32'd0;
    end else if (rdy_in) begin
      state          <= state_nx;
      pc             <= pc_nx;
      discard        <= discard_nx;
      inst_to_dec    <= inst_nx;
      pc_to_dec      <= slot_pc_nx;
      if_ls_to_dec   <= ls_nx;
      mem_fetch_req  <= req_nx;
      mem_fetch_addr <= addr_nx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      line_valid <= '0;
    end else if (rdy_in && fill_en) begin
      line_valid[fill_index] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; the valid bits alone gate use.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill_en) begin
      line_tag[fill_index]  <= fill_tag;
      line_data[fill_index] <= mem_fetch_inst;
    end
  end
endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end stage directly upstream of the decoder.
- Holds the architectural fetch PC and a direct-mapped instruction cache.
- Requests whole 32-bit instructions from the memory controller on a cache miss.
- Presents one instruction at a time to the decoder (instruction, PC, load/store flag) and holds it until the decoder reports free stations.
- Redirects on ROB jump/mispredict flush. Sequential PC+4 prediction only.

Parameters:
- ICACHE_ENTRIES, 64, number of direct-mapped lines (one instruction each); power of two; INDEX_BITS = log2(ICACHE_ENTRIES).
- RESET_PC, 32'h00000000, PC loaded on reset.
- EMPTY_PC, 32'hFFFFFFFF, value driven on pc_to_dec when no instruction is held; the decoder treats it as "no instruction".

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; when low, all state holds
- if_station_idle  input  1  decoder/ROB/RS/LSB can accept the held instruction this cycle
- inst_to_dec  output  32  held instruction word
- pc_to_dec  output  32  PC of held instruction, EMPTY_PC if none
- if_ls_to_dec  output  1  held instruction is a load (opcode 0000011) or store (opcode 0100011)
- mem_fetch_req  output  1  instruction fetch request to memory controller
- mem_fetch_addr  output  32  fetch address (word aligned)
- mem_fetch_done  input  1  one-cycle pulse: mem_fetch_inst valid
- mem_fetch_inst  input  32  fetched instruction
- rob_jump_flag  input  1  flush and redirect
- rob_jump_pc  input  32  redirect target

Behaviour:
- All state and outputs are registered and update on the rising edge of clk_in only.
- Reset (overrides everything, including an outstanding memory fetch):
  - pc=RESET_PC, state=IDLE, discard=0, all cache valid bits=0.
  - inst_to_dec=0, pc_to_dec=EMPTY_PC, if_ls_to_dec=0, mem_fetch_req=0, mem_fetch_addr=0.
  - A mem_fetch_done arriving after reset is ignored.
- rdy_in=0: no state changes; inputs ignored except rst_in.
- Output slot:
  - Valid when pc_to_dec != EMPTY_PC.
  - Consumed at an edge where the slot is valid and if_station_idle=1. The slot empties unless refilled on that same edge.
  - While if_station_idle=0 the slot holds unchanged.
- Cache addressing: index=pc[INDEX_BITS+1:2], tag=pc[31:INDEX_BITS+2].
- IDLE, slot free (empty or being consumed this edge):
  - Cache hit: slot loads {cache data, pc, ls flag} at this edge; pc<=pc+4; state stays IDLE. Back-to-back hits give one instruction per cycle.
  - Miss: mem_fetch_req<=1, mem_fetch_addr<=pc; state<=WAIT_MEM.
- IDLE, slot held and not consumed: no action.
- WAIT_MEM:
  - mem_fetch_req stays 1 with a stable address until mem_fetch_done.
  - On mem_fetch_done: write cache line (valid=1, tag, data) for mem_fetch_addr; mem_fetch_req<=0; state<=IDLE.
  - If discard=0, the slot also loads {mem_fetch_inst, mem_fetch_addr, ls flag} and pc<=pc+4.
  - If discard=1: slot is not loaded; discard<=0.
  - A hit for the next PC is checked only in the following IDLE cycle; miss latency is mem latency + 1 cycle.
- Flush (rob_jump_flag=1) has priority over consume, hit and fill:
  - slot<=empty (pc_to_dec=EMPTY_PC, if_ls_to_dec=0); pc<=rob_jump_pc.
  - In IDLE: no fetch or hit this edge; fetch of the target starts the next cycle.
  - In WAIT_MEM without mem_fetch_done the same edge: discard<=1. The request is not cancelled; the returning word still fills the cache.
  - In WAIT_MEM with mem_fetch_done the same edge: fill the cache, do not present the word, state<=IDLE, discard stays 0.
- PC arithmetic: 32-bit, wraps modulo 2^32. pc[1:0] is assumed 00; no misalignment checking.
- Cache is never invalidated after reset; there is no self-modifying-code support.

Test Plan:
- Reset, memory returns 32'h00000513 three cycles after request: mem_fetch_req=1 with addr 0x0, then pc_to_dec=0x0, inst_to_dec=32'h00000513, if_ls_to_dec=0. The next request is addr 0x4.
- Hold instruction at 0x0 with if_station_idle=0 for 5 cycles: outputs unchanged; no new mem_fetch_req after the slot fills. Raise if_station_idle: the next edge empties or refills the slot.
- After filling 0x0–0xC, flush to 0x0: slot empty for one cycle, then 0x0, 0x4, 0x8, 0xC presented on consecutive cycles with if_station_idle=1. Zero mem_fetch_req pulses.
- Fetch 32'h00002083 (lw) then 32'h00112023 (sw): if_ls_to_dec=1 for both. 32'h00000013 (addi) gives 0.
- Flush to 0x100 while WAIT_MEM for 0x8: when mem_fetch_done returns, pc_to_dec stays EMPTY_PC; the next request is addr 0x100. A later flush to 0x8 hits the cache with no request.
- rdy_in=0 mid-WAIT_MEM with mem_fetch_done held low: all outputs frozen. rst_in mid-WAIT_MEM: outputs return to reset values and mem_fetch_req=0 the next cycle.
